// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control unit: Moore FSM with memory wait/timeout handling,
// sticky bus error and instruction-boundary interrupt entry.
module multi_cycle_ctrl #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned INT_EN   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_in,
  input  logic        zero,
  input  logic        MIO_ready,
  input  logic        INT,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        CPU_MIO,
  output logic        EPCWrite,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  RegDst,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUop,
  output logic        Branch_ne,
  output logic [3:0]  state_out,
  output logic        bus_err
);

  localparam int unsigned WW = 8;
  localparam bit WAIT_ON = (MEM_WAIT != 0);
  localparam bit INT_ON  = (INT_EN != 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MEM_ADR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EX = 4'd6, S_R_WB = 4'd7,
    S_BR = 4'd8, S_JMP = 4'd9, S_I_EX = 4'd10, S_I_WB = 4'd11,
    S_JAL = 4'd12, S_JR = 4'd13, S_LUI = 4'd14, S_INT_ENT = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          bus_err_q, bus_err_d;
  logic          fin;
  logic          mem_state, mem_done, timeout;
  logic [5:0]    op, funct;
  logic          unused_bits;

  assign op          = inst_in[31:26];
  assign funct       = inst_in[5:0];
  assign unused_bits = ^{zero, inst_in[25:6]};

  assign mem_state = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_done  = !WAIT_ON || MIO_ready;
  // MIO_ready in the timeout cycle takes priority over the error
  assign timeout   = WAIT_ON && mem_state && !MIO_ready && (wait_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state decode; fin marks the last cycle of an instruction, where INT is sampled
  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    fin       = 1'b0;
    case (state_q)
      S_IF: begin
        if (timeout) begin
          state_d   = S_INT_ENT;
          bus_err_d = 1'b1;
        end else if (mem_done) begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        case (op)
          OP_LW, OP_SW:                       state_d = S_MEM_ADR;
          OP_RTYPE:                           state_d = (funct == FN_JR) ? S_JR : S_R_EX;
          OP_BEQ, OP_BNE:                     state_d = S_BR;
          OP_J:                               state_d = S_JMP;
          OP_JAL:                             state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_I_EX;
          OP_LUI:                             state_d = S_LUI;
          default:                            fin = 1'b1;
        endcase
      end
      S_MEM_ADR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        if (timeout) begin
          state_d   = S_INT_ENT;
          bus_err_d = 1'b1;
        end else if (mem_done) begin
          if (state_q == S_MEM_RD) state_d = S_MEM_WB;
          else                     fin = 1'b1;
        end
      end
      S_R_EX:    state_d = S_R_WB;
      S_I_EX:    state_d = S_I_WB;
      S_INT_ENT: state_d = S_IF;
      default:   fin = 1'b1;
    endcase
    if (fin) state_d = (INT && INT_ON) ? S_INT_ENT : S_IF;

    if (state_d != state_q)                      wait_d = '0;
    else if (WAIT_ON && mem_state && !MIO_ready) wait_d = wait_q + WW'(1);
    else                                         wait_d = wait_q;
  end

  // Moore output decode; IF write strobes qualified by transfer completion
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IRWrite = 1'b0; ALUSrcA = 1'b0; RegWrite = 1'b0;
    CPU_MIO = 1'b0; EPCWrite = 1'b0; Branch_ne = 1'b0;
    MemtoReg = 2'b00; RegDst = 2'b00; PCSource = 2'b00; ALUSrcB = 2'b00;
    ALUop = 3'b000;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1; CPU_MIO = 1'b1; ALUSrcB = 2'b01; ALUop = 3'b010;
        IRWrite = mem_done && !timeout;
        PCWrite = mem_done && !timeout;
      end
      S_ID:      begin ALUSrcB = 2'b11; ALUop = 3'b010; end
      S_MEM_ADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUop = 3'b010; end
      S_MEM_RD:  begin MemRead = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
      S_MEM_WB:  begin RegWrite = 1'b1; MemtoReg = 2'b01; end
      S_MEM_WR:  begin MemWrite = 1'b1; IorD = 1'b1; CPU_MIO = 1'b1; end
      S_R_EX: begin
        ALUSrcA = 1'b1;
        case (funct)
          6'b100010: ALUop = 3'b110;
          6'b100100: ALUop = 3'b000;
          6'b100101: ALUop = 3'b001;
          6'b101010: ALUop = 3'b111;
          default:   ALUop = 3'b010;
        endcase
      end
      S_R_WB: begin RegWrite = 1'b1; RegDst = 2'b01; end
      S_BR: begin
        ALUSrcA = 1'b1; ALUop = 3'b110; PCWriteCond = 1'b1; PCSource = 2'b01;
        Branch_ne = (op == OP_BNE);
      end
      S_JMP: begin PCWrite = 1'b1; PCSource = 2'b10; end
      S_I_EX: begin
        ALUSrcB = 2'b10;
        case (op)
          OP_SLTI: ALUop = 3'b111;
          OP_ANDI: ALUop = 3'b000;
          OP_ORI:  ALUop = 3'b001;
          default: ALUop = 3'b010;
        endcase
      end
      S_I_WB: RegWrite = 1'b1;
      S_JAL: begin
        PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1;
        RegDst = 2'b10; MemtoReg = 2'b10;
      end
      S_JR:      begin PCWrite = 1'b1; PCSource = 2'b11; end
      S_LUI:     begin RegWrite = 1'b1; MemtoReg = 2'b11; end
      S_INT_ENT: begin EPCWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b11; end
      default:   ;
    endcase
    if (reset) begin
      PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
      MemWrite = 1'b0; EPCWrite = 1'b0; PCWriteCond = 1'b0;
    end
  end

  assign state_out = state_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: dut0 single-cycle memory with interrupts,
// dut1 waited memory with TIMEOUT=4 and interrupts disabled.
module tb_multi_cycle_ctrl;

  localparam logic [3:0] IF = 4'd0, ID = 4'd1, MADR = 4'd2, MRD = 4'd3, MWB = 4'd4,
    MWR = 4'd5, REX = 4'd6, RWB = 4'd7, BR = 4'd8, JMP = 4'd9, IEX = 4'd10,
    IWB = 4'd11, JAL = 4'd12, JR = 4'd13, LUI = 4'd14, IENT = 4'd15;

  localparam logic [31:0] I_LW = 32'h8C220004, I_SW = 32'hAC220004, I_BEQ = 32'h10220003,
    I_BNE = 32'h14220003, I_ADD = 32'h00221820, I_SUB = 32'h00221822, I_SLT = 32'h0022182A,
    I_ORI = 32'h34220005, I_SLTI = 32'h28220005, I_J = 32'h08000010, I_JAL = 32'h0C000010,
    I_JR = 32'h03E00008, I_LUI = 32'h3C011234, I_UND = 32'hFC000000;

  logic clk, reset;
  logic [31:0] inst0, inst1;
  logic zero0, zero1, rdy0, rdy1, int0, int1;

  logic pcw0, pcwc0, iord0, mrd0, mwr0, irw0, asa0, rw0, mio0, epc0, bne0, berr0;
  logic [1:0] m2r0, rd0, pcs0, asb0;
  logic [2:0] aop0;
  logic [3:0] st0;
  logic pcw1, pcwc1, iord1, mrd1, mwr1, irw1, asa1, rw1, mio1, epc1, bne1, berr1;
  logic [1:0] m2r1, rd1, pcs1, asb1;
  logic [2:0] aop1;
  logic [3:0] st1;

  multi_cycle_ctrl #(.MEM_WAIT(0), .TIMEOUT(16), .INT_EN(1)) dut0 (
    .clk(clk), .reset(reset), .inst_in(inst0), .zero(zero0), .MIO_ready(rdy0), .INT(int0),
    .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mrd0), .MemWrite(mwr0),
    .IRWrite(irw0), .ALUSrcA(asa0), .RegWrite(rw0), .CPU_MIO(mio0), .EPCWrite(epc0),
    .MemtoReg(m2r0), .RegDst(rd0), .PCSource(pcs0), .ALUSrcB(asb0), .ALUop(aop0),
    .Branch_ne(bne0), .state_out(st0), .bus_err(berr0));

  multi_cycle_ctrl #(.MEM_WAIT(1), .TIMEOUT(4), .INT_EN(0)) dut1 (
    .clk(clk), .reset(reset), .inst_in(inst1), .zero(zero1), .MIO_ready(rdy1), .INT(int1),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
    .IRWrite(irw1), .ALUSrcA(asa1), .RegWrite(rw1), .CPU_MIO(mio1), .EPCWrite(epc1),
    .MemtoReg(m2r1), .RegDst(rd1), .PCSource(pcs1), .ALUSrcB(asb1), .ALUop(aop1),
    .Branch_ne(bne1), .state_out(st1), .bus_err(berr1));

  logic [26:0] act0, act1;
  assign act0 = {st0, pcw0, pcwc0, iord0, mrd0, mwr0, irw0, asa0, rw0, mio0, epc0,
                 m2r0, rd0, pcs0, asb0, aop0, bne0, berr0};
  assign act1 = {st1, pcw1, pcwc1, iord1, mrd1, mwr1, irw1, asa1, rw1, mio1, epc1,
                 m2r1, rd1, pcs1, asb1, aop1, bne1, berr1};

  logic [10:0] imm0, imm1;
  assign imm0 = {st0, berr0, pcw0, irw0, rw0, mwr0, epc0, pcwc0};
  assign imm1 = {st1, berr1, pcw1, irw1, rw1, mwr1, epc1, pcwc1};

  typedef struct {
    int         d;
    logic [3:0] st;
    logic       pulse;
    logic       bne;
    logic [2:0] aop;
    logic       berr;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Expected strobes/selects per state, straight from the state output table
  function automatic logic [21:0] spec_out(logic [3:0] st, logic pulse, logic bne, logic [2:0] aop);
    logic pcw, pcwc, iord, mrd, mwr, irw, asa, rw, mio, epc, bn;
    logic [1:0] m2r, rd, pcs, asb;
    logic [2:0] op;
    {pcw, pcwc, iord, mrd, mwr, irw, asa, rw, mio, epc, bn} = '0;
    {m2r, rd, pcs, asb, op} = '0;
    case (st)
      IF:   begin mrd = 1; mio = 1; asb = 2'b01; op = 3'b010; pcw = pulse; irw = pulse; end
      ID:   begin asb = 2'b11; op = 3'b010; end
      MADR: begin asa = 1; asb = 2'b10; op = 3'b010; end
      MRD:  begin mrd = 1; iord = 1; mio = 1; end
      MWB:  begin rw = 1; m2r = 2'b01; end
      MWR:  begin mwr = 1; iord = 1; mio = 1; end
      REX:  begin asa = 1; op = aop; end
      RWB:  begin rw = 1; rd = 2'b01; end
      BR:   begin asa = 1; op = 3'b110; pcwc = 1; pcs = 2'b01; bn = bne; end
      JMP:  begin pcw = 1; pcs = 2'b10; end
      IEX:  begin asb = 2'b10; op = aop; end
      IWB:  rw = 1;
      JAL:  begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      JR:   begin pcw = 1; pcs = 2'b11; end
      LUI:  begin rw = 1; m2r = 2'b11; end
      IENT: begin epc = 1; pcw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, asa, rw, mio, epc, m2r, rd, pcs, asb, op, bn};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: the FSM presents an output every cycle; check mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [26:0] want, got;
      e    = sb.pop_front();
      want = {e.st, spec_out(e.st, e.pulse, e.bne, e.aop), e.berr};
      got  = (e.d == 0) ? act0 : act1;
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s dut%0d: got state=%0d outs=%h berr=%b, expected state=%0d outs=%h berr=%b",
                 e.tag, e.d, got[26:23], got[22:1], got[0], want[26:23], want[22:1], want[0]);
      end
    end
  end

  // Immediate check of state, bus_err and write strobes {PCWrite,IRWrite,RegWrite,MemWrite,EPCWrite,PCWriteCond}
  task automatic chk_now(input int d, input logic [3:0] st, input logic berr,
                         input logic [5:0] wr, input string tag);
    logic [10:0] got, want;
    got  = (d == 0) ? imm0 : imm1;
    want = {st, berr, wr};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got state=%0d berr=%b wr=%b, expected state=%0d berr=%b wr=%b",
               tag, d, got[10:7], got[6], got[5:0], want[10:7], want[6], want[5:0]);
    end
  endtask

  task automatic step(input int d, input logic [31:0] inst, input logic rdy, input logic intr,
                      input logic [3:0] st, input logic pulse, input logic bne,
                      input logic [2:0] aop, input logic berr, input string tag);
    if (d == 0) begin inst0 = inst; rdy0 = rdy; int0 = intr; end
    else        begin inst1 = inst; rdy1 = rdy; int1 = intr; end
    sb.push_back('{d, st, pulse, bne, aop, berr, tag});
    @(posedge clk);
    #1;
  endtask

  // One cycle of reset: expect IF with all write strobes low and bus_err cleared
  task automatic rst_cycle(input int d, input string tag);
    reset = 1'b1;
    #1;
    chk_now(d, IF, 1'b0, 6'b000000, {tag, "_async"});
    sb.push_back('{d, IF, 1'b0, 1'b0, 3'b000, 1'b0, tag});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst0 = I_UND; inst1 = I_UND;
    zero0 = 1'b1;  zero1 = 1'b1;
    rdy0 = 1'b1;   rdy1 = 1'b1;
    int0 = 1'b0;   int1 = 1'b0;
    @(posedge clk);
    #1;

    // dut0: MEM_WAIT=0, INT_EN=1
    rst_cycle(0, "reset0");
    step(0, I_LW, 1, 0, IF,   1, 0, 3'b000, 0, "lw_if");
    step(0, I_LW, 1, 0, ID,   0, 0, 3'b000, 0, "lw_id");
    step(0, I_LW, 1, 0, MADR, 0, 0, 3'b000, 0, "lw_adr");
    step(0, I_LW, 1, 0, MRD,  0, 0, 3'b000, 0, "lw_rd");
    step(0, I_LW, 1, 0, MWB,  0, 0, 3'b000, 0, "lw_wb");
    step(0, I_BEQ, 1, 0, IF,  1, 0, 3'b000, 0, "beq_if");
    step(0, I_BEQ, 1, 0, ID,  0, 0, 3'b000, 0, "beq_id");
    step(0, I_BEQ, 1, 0, BR,  0, 0, 3'b000, 0, "beq_br");
    step(0, I_BNE, 1, 0, IF,  1, 0, 3'b000, 0, "bne_if");
    step(0, I_BNE, 1, 0, ID,  0, 0, 3'b000, 0, "bne_id");
    step(0, I_BNE, 1, 0, BR,  0, 1, 3'b000, 0, "bne_br");
    step(0, I_ADD, 1, 0, IF,  1, 0, 3'b000, 0, "add_if");
    step(0, I_ADD, 1, 0, ID,  0, 0, 3'b000, 0, "add_id");
    step(0, I_ADD, 1, 1, REX, 0, 0, 3'b010, 0, "add_ex_int");
    step(0, I_ADD, 1, 1, RWB, 0, 0, 3'b000, 0, "add_wb_int");
    step(0, I_ADD, 1, 0, IENT, 0, 0, 3'b000, 0, "int_ent");
    step(0, I_SUB, 1, 0, IF,  1, 0, 3'b000, 0, "sub_if");
    step(0, I_SUB, 1, 0, ID,  0, 0, 3'b000, 0, "sub_id");
    step(0, I_SUB, 1, 0, REX, 0, 0, 3'b110, 0, "sub_ex");
    step(0, I_SUB, 1, 0, RWB, 0, 0, 3'b000, 0, "sub_wb");
    step(0, I_SLT, 1, 0, IF,  1, 0, 3'b000, 0, "slt_if");
    step(0, I_SLT, 1, 0, ID,  0, 0, 3'b000, 0, "slt_id");
    step(0, I_SLT, 1, 0, REX, 0, 0, 3'b111, 0, "slt_ex");
    step(0, I_SLT, 1, 0, RWB, 0, 0, 3'b000, 0, "slt_wb");
    step(0, I_ORI, 1, 0, IF,  1, 0, 3'b000, 0, "ori_if");
    step(0, I_ORI, 1, 0, ID,  0, 0, 3'b000, 0, "ori_id");
    step(0, I_ORI, 1, 0, IEX, 0, 0, 3'b001, 0, "ori_ex");
    step(0, I_ORI, 1, 0, IWB, 0, 0, 3'b000, 0, "ori_wb");
    step(0, I_SLTI, 1, 0, IF, 1, 0, 3'b000, 0, "slti_if");
    step(0, I_SLTI, 1, 0, ID, 0, 0, 3'b000, 0, "slti_id");
    step(0, I_SLTI, 1, 0, IEX, 0, 0, 3'b111, 0, "slti_ex");
    step(0, I_SLTI, 1, 0, IWB, 0, 0, 3'b000, 0, "slti_wb");
    step(0, I_J,   1, 0, IF,  1, 0, 3'b000, 0, "j_if");
    step(0, I_J,   1, 0, ID,  0, 0, 3'b000, 0, "j_id");
    step(0, I_J,   1, 0, JMP, 0, 0, 3'b000, 0, "j_jmp");
    step(0, I_JAL, 1, 0, IF,  1, 0, 3'b000, 0, "jal_if");
    step(0, I_JAL, 1, 0, ID,  0, 0, 3'b000, 0, "jal_id");
    step(0, I_JAL, 1, 0, JAL, 0, 0, 3'b000, 0, "jal_jal");
    step(0, I_JR,  1, 0, IF,  1, 0, 3'b000, 0, "jr_if");
    step(0, I_JR,  1, 0, ID,  0, 0, 3'b000, 0, "jr_id");
    step(0, I_JR,  1, 0, JR,  0, 0, 3'b000, 0, "jr_jr");
    step(0, I_LUI, 1, 0, IF,  1, 0, 3'b000, 0, "lui_if");
    step(0, I_LUI, 1, 0, ID,  0, 0, 3'b000, 0, "lui_id");
    step(0, I_LUI, 1, 0, LUI, 0, 0, 3'b000, 0, "lui_lui");
    step(0, I_UND, 1, 0, IF,  1, 0, 3'b000, 0, "und_if");
    step(0, I_UND, 1, 0, ID,  0, 0, 3'b000, 0, "und_id");
    step(0, I_LW,  1, 0, IF,  1, 0, 3'b000, 0, "und_back_if");
    step(0, I_LW,  1, 0, ID,  0, 0, 3'b000, 0, "lw2_id");
    step(0, I_LW,  1, 0, MADR, 0, 0, 3'b000, 0, "lw2_adr");
    rst_cycle(0, "reset_in_mem_rd");
    step(0, I_LW,  1, 0, IF,  1, 0, 3'b000, 0, "post_reset_if");
    step(0, I_LW,  1, 0, ID,  0, 0, 3'b000, 0, "post_reset_id");
    inst0 = I_UND;

    // dut1: MEM_WAIT=1, TIMEOUT=4, INT_EN=0
    rst_cycle(1, "reset1");
    step(1, I_SW, 0, 0, IF,   0, 0, 3'b000, 0, "sw_if_wait");
    step(1, I_SW, 1, 0, IF,   1, 0, 3'b000, 0, "sw_if_done");
    step(1, I_SW, 1, 0, ID,   0, 0, 3'b000, 0, "sw_id");
    step(1, I_SW, 1, 0, MADR, 0, 0, 3'b000, 0, "sw_adr");
    for (int i = 0; i < 3; i++)
      step(1, I_SW, 0, 0, MWR, 0, 0, 3'b000, 0, "sw_wr_wait");
    step(1, I_SW, 1, 0, MWR,  0, 0, 3'b000, 0, "sw_wr_ready_at_limit");
    step(1, I_ADD, 1, 0, IF,  1, 0, 3'b000, 0, "add1_if");
    step(1, I_ADD, 1, 0, ID,  0, 0, 3'b000, 0, "add1_id");
    step(1, I_ADD, 1, 1, REX, 0, 0, 3'b010, 0, "add1_ex_int");
    step(1, I_ADD, 1, 1, RWB, 0, 0, 3'b000, 0, "add1_wb_int");
    for (int i = 0; i < 4; i++)
      step(1, I_ADD, 0, 0, IF, 0, 0, 3'b000, 0, "if_stuck");
    chk_now(1, IENT, 1'b1, 6'b100010, "expired_wait");
    step(1, I_ADD, 1, 0, IENT, 0, 0, 3'b000, 1, "timeout_int_ent");
    step(1, I_ADD, 1, 0, IF,  1, 0, 3'b000, 1, "after_timeout_if");
    step(1, I_ADD, 1, 0, ID,  0, 0, 3'b000, 1, "bus_err_sticky");
    rst_cycle(1, "reset_clears_bus_err");
    step(1, I_ADD, 1, 0, IF,  1, 0, 3'b000, 0, "final_if");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
